imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Upstream feeder of the CPU core (mcu/regs/pc/alu) and owner of the instruction memory.
//  Receives a program as a valid/ready word stream and writes it into an internal instruction RAM.
//  Checks the program with a modular checksum and holds the CPU in reset while loading.
//  After a good load it releases the CPU and serves imem_data for the CPU's imem_addr.
// PARAMETERS
//  INST_WIDTH   `INST_WIDTH (8)   instruction word width, bits
//  INST_DEPTH   `INST_DEPTH (8)   instruction address width; RAM holds 2**INST_DEPTH words
// PORTS
//  clk        in   1           clock, all state updates on rising edge
//  rst        in   1           asynchronous, active-low reset
//  load_start in   1           one-cycle request to start loading a program
//  load_len   in   INST_DEPTH  program length in words; sampled when load_start is accepted
//  s_valid    in   1           stream word valid
//  s_data     in   INST_WIDTH  stream word: program words, then one checksum word
//  s_ready    out  1           loader accepts s_data this cycle
//  imem_addr  in   INST_DEPTH  CPU fetch address (pc addr_out)
//  imem_data  out  INST_WIDTH  instruction at imem_addr
//  cpu_rst    out  1           active-high reset to the CPU core
//  load_done  out  1           a program is loaded, checked, and running
//  load_err   out  1           checksum of the last load failed
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, wr_ptr=0, sum=0, cpu_rst=1, load_done=0, load_err=0.
//   RAM contents are not reset.
//  FSM, registered: IDLE, LOAD, CHECK, RUN, ERROR.
//  s_ready = (state==LOAD || state==CHECK). A handshake is s_valid && s_ready.
//  IDLE : load_start && load_len!=0 -> LOAD. Latch len, wr_ptr=0, sum=0.
//         load_start with load_len==0 is ignored; stay in IDLE.
//  LOAD : each handshake does mem[wr_ptr]<=s_data, wr_ptr++, sum<=sum+s_data (mod 2**INST_WIDTH).
//         The handshake that writes word len-1 moves to CHECK. No wrap: len <= 2**INST_DEPTH-1.
//         A cycle without a handshake changes nothing.
//  CHECK: on handshake, test (sum+s_data) mod 2**INST_WIDTH.
//         ==0 -> RUN, load_done<=1.  !=0 -> ERROR, load_err<=1.
//         The checksum word is never written to RAM.
//  RUN  : imem_data = mem[imem_addr], combinational read, 0-cycle latency.
//         load_start && load_len!=0 -> LOAD, load_done<=0.
//  ERROR: s_ready=0. load_start && load_len!=0 -> LOAD, load_err<=0.
//  load_start is ignored in LOAD and CHECK.
//  imem_data = {INST_WIDTH{1'b0}} in every state except RUN.
//  cpu_rst is registered: cpu_rst<=(next_state!=RUN).
//   It deasserts on the edge that enters RUN and asserts on the edge that leaves RUN.
//  Simultaneous CPU fetch and stream traffic cannot happen: the RAM is only written in LOAD,
//   and the CPU is held in reset there.
//  Reset mid-load: return to IDLE. Partially written RAM stays; the CPU stays in reset.
// STRUCTURE
//  Add to defs.v: LDR_IDLE/LDR_LOAD/LDR_CHECK/LDR_RUN/LDR_ERROR encodings and `LDR_STATE_WIDTH (3).
//  One sub-module, imem_ram: 2**INST_DEPTH x INST_WIDTH, one sync write port, one async read port.
//  imem_loader holds the FSM, wr_ptr, len and sum registers, and the output muxing.
// TESTING
//  1 Reset: hold rst=0 -> cpu_rst=1, s_ready=0, load_done=0, load_err=0, imem_data=8'h00.
//  2 Good load: load_start, len=3; stream 01,AE,05, then checksum 4C.
//    Expect load_done=1 and cpu_rst=0 after the last edge; imem_addr=1 -> imem_data=8'hAE.
//  3 Bad checksum: same stream with 4D -> load_err=1, cpu_rst stays 1, imem_data=00,
//    s_ready=0. A new load_start clears load_err.
//  4 Throttled stream: s_valid low every other cycle.
//    Same final RAM and load_done as test 2; wr_ptr advances only on handshakes.
//  5 Reset mid-load: rst=0 after 2 words -> IDLE, s_ready=0. A full reload then passes as in test 2.
//  6 Reload while running: load_start in RUN with len=1, stream 7F then checksum 81.
//    cpu_rst=1 and load_done=0 the next cycle, then RUN with mem[0]=7F.
//  7 len=0 with load_start in IDLE -> no state change, s_ready stays 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM encoding, the memory geometry and the checksum rule.
package imem_loader_pkg;

  localparam int INST_WIDTH      = 8;
  localparam int INST_DEPTH      = 8;
  localparam int LDR_STATE_WIDTH = 3;

  localparam logic [INST_DEPTH-1:0] PTR_ONE = {{(INST_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [LDR_STATE_WIDTH-1:0] {
    LDR_IDLE  = 3'd0,
    LDR_LOAD  = 3'd1,
    LDR_CHECK = 3'd2,
    LDR_RUN   = 3'd3,
    LDR_ERROR = 3'd4
  } ldr_state_t;

  // A program is good when its words plus the trailing checksum word sum to zero.
  function automatic logic chk_ok(input logic [INST_WIDTH-1:0] sum,
                                  input logic [INST_WIDTH-1:0] word);
    logic [INST_WIDTH-1:0] total;
    total  = sum + word;
    chk_ok = (total == '0);
  endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a partial load survives a reset.
module imem_loader_ram
  import imem_loader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [INST_DEPTH-1:0] i_waddr,
  input  logic [INST_WIDTH-1:0] i_wdata,
  input  logic [INST_DEPTH-1:0] i_raddr,
  output logic [INST_WIDTH-1:0] o_rdata
);

  logic [INST_WIDTH-1:0] r_mem [2**INST_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams a checksummed program into instruction RAM, holds the
// CPU in reset while loading, and serves instruction fetches once the load is good.
//
// state     | meaning
// LDR_IDLE  | after reset, waiting for a non-empty load request
// LDR_LOAD  | accepting program words into RAM
// LDR_CHECK | waiting for the checksum word
// LDR_RUN   | program good, CPU released, fetches served
// LDR_ERROR | checksum failed, CPU held in reset
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load_start,
  input  logic [INST_DEPTH-1:0] i_load_len,
  input  logic                  i_s_valid,
  input  logic [INST_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  input  logic [INST_DEPTH-1:0] i_imem_addr,
  output logic [INST_WIDTH-1:0] o_imem_data,
  output logic                  o_cpu_rst,
  output logic                  o_load_done,
  output logic                  o_load_err
);

  ldr_state_t            r_state;
  ldr_state_t            w_next;
  logic [INST_DEPTH-1:0] r_wr_ptr;
  logic [INST_DEPTH-1:0] r_len;
  logic [INST_WIDTH-1:0] r_sum;
  logic                  r_cpu_rst;
  logic                  r_load_done;
  logic                  r_load_err;

  logic                  w_start;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_we;
  logic                  w_begin;
  logic [INST_WIDTH-1:0] w_rd_data;

  always_comb begin
    w_next      = r_state;
    o_s_ready   = 1'b0;
    o_imem_data = '0;
    w_start     = i_load_start && (i_load_len != '0);
    w_last      = (r_wr_ptr == (r_len - PTR_ONE));

    if ((r_state == LDR_LOAD) || (r_state == LDR_CHECK)) begin
      o_s_ready = 1'b1;
    end
    w_hs = i_s_valid && o_s_ready;
    w_we = w_hs && (r_state == LDR_LOAD);

    case (r_state)
      LDR_IDLE, LDR_RUN, LDR_ERROR: begin
        if (w_start) begin
          w_next = LDR_LOAD;
        end
      end
      LDR_LOAD: begin
        if (w_hs && w_last) begin
          w_next = LDR_CHECK;
        end
      end
      LDR_CHECK: begin
        if (w_hs) begin
          w_next = chk_ok(r_sum, i_s_data) ? LDR_RUN : LDR_ERROR;
        end
      end
      default: w_next = LDR_IDLE;
    endcase

    // Only a load request accepted outside LOAD/CHECK restarts the pointer and sum.
    w_begin = (w_next == LDR_LOAD) && (r_state != LDR_LOAD);

    if (r_state == LDR_RUN) begin
      o_imem_data = w_rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= LDR_IDLE;
      r_cpu_rst   <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_rst   <= (w_next != LDR_RUN);
      r_load_done <= (w_next == LDR_RUN);
      r_load_err  <= (w_next == LDR_ERROR);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_len    <= '0;
      r_sum    <= '0;
    end else if (w_begin) begin
      r_wr_ptr <= '0;
      r_len    <= i_load_len;
      r_sum    <= '0;
    end else if (w_we) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_sum    <= r_sum + i_s_data;
    end
  end

  imem_loader_ram u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_s_data),
    .i_raddr (i_imem_addr),
    .o_rdata (w_rd_data)
  );

  assign o_cpu_rst   = r_cpu_rst;
  assign o_load_done = r_load_done;
  assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed program loads plus randomized ones,
// with load outcomes checked by a monitor and RAM contents against a reference image.
module tb_imem_loader;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_load_start;
  logic [7:0] i_load_len;
  logic       i_s_valid;
  logic [7:0] i_s_data;
  logic       o_s_ready;
  logic [7:0] i_imem_addr;
  logic [7:0] o_imem_data;
  logic       o_cpu_rst;
  logic       o_load_done;
  logic       o_load_err;

  imem_loader dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load_start (i_load_start),
    .i_load_len   (i_load_len),
    .i_s_valid    (i_s_valid),
    .i_s_data     (i_s_data),
    .o_s_ready    (o_s_ready),
    .i_imem_addr  (i_imem_addr),
    .o_imem_data  (o_imem_data),
    .o_cpu_rst    (o_cpu_rst),
    .o_load_done  (o_load_done),
    .o_load_err   (o_load_err)
  );

  always #5 i_clk = ~i_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   exp_q[$];          // expected outcome of each checksummed load: 1 = good
  logic [7:0] model_mem [256];
  bit         written   [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising load_done/load_err is a load outcome to score.
  bit prev_done = 1'b0;
  bit prev_err  = 1'b0;
  always @(negedge i_clk) begin
    bit e;
    if (o_load_done && !prev_done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("outcome_done", 1, {31'd0, e});
        check("run_cpu_rst", {31'd0, o_cpu_rst}, 0);
      end
    end
    if (o_load_err && !prev_err) begin
      if (exp_q.size() == 0) check("unexpected_err", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("outcome_err", 0, {31'd0, e});
        check("err_cpu_rst", {31'd0, o_cpu_rst}, 1);
        check("err_s_ready", {31'd0, o_s_ready}, 0);
        check("err_imem_data", {24'd0, o_imem_data}, 0);
      end
    end
    prev_done = o_load_done;
    prev_err  = o_load_err;
  end

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n   = 1'b0;
    i_s_valid = 1'b0;
    #1;
    check("rst_s_ready", {31'd0, o_s_ready}, 0);
    check("rst_cpu_rst", {31'd0, o_cpu_rst}, 1);
    check("rst_load_done", {31'd0, o_load_done}, 0);
    check("rst_load_err", {31'd0, o_load_err}, 0);
    check("rst_imem_data", {24'd0, o_imem_data}, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic start_load(input logic [7:0] len);
    i_load_start = 1'b1;
    i_load_len   = len;
    @(negedge i_clk);
    i_load_start = 1'b0;
    i_load_len   = 8'($urandom);
    check("start_s_ready", {31'd0, o_s_ready}, 1);
    check("start_cpu_rst", {31'd0, o_cpu_rst}, 1);
    check("start_load_done", {31'd0, o_load_done}, 0);
    check("start_load_err", {31'd0, o_load_err}, 0);
  endtask

  // Called and returns at a negedge; the handshake happens on the edge in between.
  task automatic send_word(input logic [7:0] d, input bit thr);
    int budget = 0;
    if (thr) begin
      i_s_valid = 1'b0;
      i_s_data  = 8'($urandom);
      @(negedge i_clk);
    end
    i_s_valid = 1'b1;
    i_s_data  = d;
    while (!o_s_ready && budget < 50) begin
      @(negedge i_clk);
      budget++;
    end
    if (budget >= 50) check("s_ready_timeout", 0, 1);
    @(negedge i_clk);
    i_s_valid = 1'b0;
    i_s_data  = 8'($urandom);
  endtask

  task automatic readback(input logic [7:0] len);
    for (int a = 0; a < int'(len); a++) begin
      @(negedge i_clk);
      i_imem_addr = 8'(a);
      #1;
      check("ram_prog", {24'd0, o_imem_data}, {24'd0, model_mem[a]});
    end
    for (int k = 0; k < 4; k++) begin
      int a = int'($urandom_range(255, 0));
      if (written[a]) begin
        @(negedge i_clk);
        i_imem_addr = 8'(a);
        #1;
        check("ram_old", {24'd0, o_imem_data}, {24'd0, model_mem[a]});
      end
    end
  endtask

  task automatic run_load(input logic [7:0] prog[$], input bit bad, input bit thr, input bit poke);
    logic [7:0] sum = 8'd0;
    logic [7:0] ck;
    int         budget = 0;
    start_load(8'(prog.size()));
    foreach (prog[i]) begin
      send_word(prog[i], thr && (($urandom & 1) == 1 || i == 0));
      sum          = sum + prog[i];
      model_mem[i] = prog[i];
      written[i]   = 1'b1;
      if (poke && i == 0) begin
        i_load_start = 1'b1;
        i_load_len   = 8'd1;
        @(negedge i_clk);
        i_load_start = 1'b0;
      end
    end
    ck = 8'd0 - sum;
    if (bad) ck = ck + 8'd1;
    exp_q.push_back(!bad);
    send_word(ck, thr);
    while (exp_q.size() != 0 && budget < 5) begin
      @(negedge i_clk);
      budget++;
    end
    check("outcome_seen", exp_q.size(), 0);
    check("end_load_done", {31'd0, o_load_done}, {31'd0, !bad});
    check("end_load_err", {31'd0, o_load_err}, {31'd0, bad});
    check("end_cpu_rst", {31'd0, o_cpu_rst}, {31'd0, bad});
    if (!bad) readback(8'(prog.size()));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p[$];
    i_rst_n = 1'b0; i_load_start = 1'b0; i_load_len = 8'd0;
    i_s_valid = 1'b0; i_s_data = 8'd0; i_imem_addr = 8'd0;
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    do_reset();

    // len==0 in IDLE is ignored
    @(negedge i_clk);
    i_load_start = 1'b1; i_load_len = 8'd0;
    @(negedge i_clk);
    i_load_start = 1'b0;
    check("len0_idle_s_ready", {31'd0, o_s_ready}, 0);
    check("len0_idle_cpu_rst", {31'd0, o_cpu_rst}, 1);

    p = '{8'h01, 8'hAE, 8'h05};
    run_load(p, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_imem_addr = 8'd1;
    #1;
    check("good_addr1", {24'd0, o_imem_data}, 32'hAE);

    // len==0 in RUN keeps running
    @(negedge i_clk);
    i_load_start = 1'b1; i_load_len = 8'd0;
    @(negedge i_clk);
    i_load_start = 1'b0;
    check("len0_run_done", {31'd0, o_load_done}, 1);
    check("len0_run_cpu_rst", {31'd0, o_cpu_rst}, 0);

    p = '{8'h7F};
    run_load(p, 1'b0, 1'b0, 1'b0);

    p = '{8'h01, 8'hAE, 8'h05};
    run_load(p, 1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    check("err_hold", {31'd0, o_load_err}, 1);
    check("err_hold_data", {24'd0, o_imem_data}, 0);

    run_load(p, 1'b0, 1'b1, 1'b0);

    // Reset after two words, then a full reload
    start_load(8'd3);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    model_mem[0] = 8'h11; model_mem[1] = 8'h22;
    written[0] = 1'b1; written[1] = 1'b1;
    do_reset();
    check("midrst_done", {31'd0, o_load_done}, 0);
    run_load(p, 1'b0, 1'b0, 1'b0);

    // load_start during LOAD is ignored
    run_load(p, 1'b0, 1'b1, 1'b1);

    for (int n = 0; n < 30; n++) begin
      int len = int'($urandom_range(40, 1));
      p = {};
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      run_load(p, ($urandom_range(4, 0) == 0), ($urandom & 1) == 1, 1'b0);
    end

    repeat (3) @(negedge i_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
